cpu_step_ctrl: RTL and testbench

Sequences the 6502 core's clock enable from one fast system clock. It replaces ad-hoc manual/auto clock muxing with a single controller. It debounces the step, mode and reset keys, stretches CPU reset across several enabled cycles, and supports single-step, free-run at a divided rate, and halt on an address breakpoint. The CPU and memories run on clk, gated by cpu_ce.

---
 rtl/cpu_step_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Clock-enable sequencer for a 6502 core: debounced keys, stretched CPU reset,
// single-step, divided free-run and address-breakpoint halt.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RUN_DIV         = 262144,
    parameter int RESET_PULSES    = 8,
    parameter int CNT_W           = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_step_n,
    input  logic             key_mode_n,
    input  logic             key_reset_n,
    input  logic [15:0]      cpu_addr,
    input  logic [15:0]      bp_addr,
    input  logic             bp_en,
    output logic             cpu_ce,
    output logic             cpu_reset,
    output logic             running,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       state_dbg
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(RUN_DIV);
    localparam int PUL_W = $clog2(RESET_PULSES + 1);

    typedef enum logic [1:0] {
        S_RESET_SEQ = 2'd0,
        S_STOPPED   = 2'd1,
        S_RUNNING   = 2'd2,
        S_BP_HALT   = 2'd3
    } state_t;

    // Key index: 0 = step, 1 = mode, 2 = reset. r_db is 1 when pressed.
    logic [2:0]      w_key_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [2:0]      r_evt;
    logic [DB_W-1:0] r_db_cnt [3];

    assign w_key_raw = {key_reset_n, key_mode_n, key_step_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
            r_db    <= 3'b000;
            r_evt   <= 3'b000;
            for (int k = 0; k < 3; k++) r_db_cnt[k] <= '0;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 3; k++) begin
                r_evt[k] <= 1'b0;
                if (!r_sync2[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[k]     <= !r_sync2[k];
                    r_evt[k]    <= !r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
            end
        end
    end

    state_t             r_state;
    logic               r_ce;
    logic               r_cpu_reset;
    logic               r_running;
    logic               r_bp_hit;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [PUL_W-1:0]   r_rst_pulses;

    state_t             w_state_nxt;
    logic               w_ce_nxt;
    logic               w_cpu_reset_nxt;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [PUL_W-1:0]   w_pulses_nxt;
    logic               w_div_done;
    logic               w_bp_match;

    assign w_div_done = (r_div == DIV_W'(RUN_DIV - 1));
    // The address is judged during the enabled clk itself, before the CPU advances.
    assign w_bp_match = r_ce && !r_cpu_reset && bp_en && (cpu_addr == bp_addr);

    always_comb begin
        w_state_nxt     = r_state;
        w_ce_nxt        = 1'b0;
        w_cpu_reset_nxt = r_cpu_reset;
        w_div_nxt       = r_div;
        w_pulses_nxt    = r_rst_pulses;
        if (r_evt[2]) begin
            w_state_nxt     = S_RESET_SEQ;
            w_cpu_reset_nxt = 1'b1;
            w_div_nxt       = '0;
            w_pulses_nxt    = '0;
        end else if (w_bp_match) begin
            w_state_nxt = S_BP_HALT;
        end else begin
            case (r_state)
                S_RESET_SEQ: begin
                    if (r_rst_pulses == PUL_W'(RESET_PULSES)) begin
                        w_cpu_reset_nxt = 1'b0;
                        w_state_nxt     = S_STOPPED;
                        w_div_nxt       = '0;
                    end else if (w_div_done) begin
                        w_ce_nxt     = 1'b1;
                        w_div_nxt    = '0;
                        w_pulses_nxt = r_rst_pulses + 1'b1;
                    end else begin
                        w_div_nxt = r_div + 1'b1;
                    end
                end
                S_STOPPED: begin
                    if (r_evt[1]) begin
                        w_state_nxt = S_RUNNING;
                        w_div_nxt   = '0;
                    end else if (r_evt[0] && !r_ce) begin
                        w_ce_nxt = 1'b1;
                    end
                end
                S_RUNNING: begin
                    if (r_evt[1]) begin
                        w_state_nxt = S_STOPPED;
                    end else if (w_div_done) begin
                        w_ce_nxt  = 1'b1;
                        w_div_nxt = '0;
                    end else begin
                        w_div_nxt = r_div + 1'b1;
                    end
                end
                default: begin
                    if (r_evt[1]) begin
                        w_state_nxt = S_RUNNING;
                        w_div_nxt   = '0;
                    end else if (r_evt[0]) begin
                        w_ce_nxt    = 1'b1;
                        w_state_nxt = S_STOPPED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RESET_SEQ;
            r_ce         <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_running    <= 1'b0;
            r_bp_hit     <= 1'b0;
            r_cycle_cnt  <= '0;
            r_div        <= '0;
            r_rst_pulses <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ce         <= w_ce_nxt;
            r_cpu_reset  <= w_cpu_reset_nxt;
            r_running    <= (w_state_nxt == S_RUNNING);
            r_bp_hit     <= (w_state_nxt == S_BP_HALT);
            r_div        <= w_div_nxt;
            r_rst_pulses <= w_pulses_nxt;
            if (r_ce && !r_cpu_reset) r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign cpu_ce      = r_ce;
    assign cpu_reset   = r_cpu_reset;
    assign running     = r_running;
    assign bp_hit      = r_bp_hit;
    assign cycle_count = r_cycle_cnt;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with small debounce/divider/reset-pulse values.
module tb_cpu_step_ctrl;

    localparam int CNT_W = 24;
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_STOP  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_BP    = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             key_step_n;
    logic             key_mode_n;
    logic             key_reset_n;
    logic [15:0]      cpu_addr;
    logic [15:0]      bp_addr;
    logic             bp_en;
    logic             cpu_ce;
    logic             cpu_reset;
    logic             running;
    logic             bp_hit;
    logic [CNT_W-1:0] cycle_count;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    int ce_total = 0;
    int ce_snap = 0;
    logic prev_ce = 1'b0;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV(5),
        .RESET_PULSES(3),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_step_n(key_step_n),
        .key_mode_n(key_mode_n),
        .key_reset_n(key_reset_n),
        .cpu_addr(cpu_addr),
        .bp_addr(bp_addr),
        .bp_en(bp_en),
        .cpu_ce(cpu_ce),
        .cpu_reset(cpu_reset),
        .running(running),
        .bp_hit(bp_hit),
        .cycle_count(cycle_count),
        .state_dbg(state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulse monitor: counts enables and checks they are never back to back
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_ce) begin
                ce_total++;
                check("ce_single_width", 32'(prev_ce), 32'd0);
            end
            prev_ce = cpu_ce;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ce(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (cpu_ce) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        key_step_n  = 1'b1;
        key_mode_n  = 1'b1;
        key_reset_n = 1'b1;
        cpu_addr    = 16'h0000;
        bp_addr     = 16'h0000;
        bp_en       = 1'b0;
        ticks(3);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_ce", 32'(cpu_ce), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        check("rst_count", 32'(cycle_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_RESET));

        // reset sequence: pulses at edges 5, 10, 15, release at 16
        rst_n = 1'b1;
        ticks(4);
        check("rseq_ce_e4", 32'(cpu_ce), 32'd0);
        tick();
        check("rseq_ce_e5", 32'(cpu_ce), 32'd1);
        check("rseq_reset_e5", 32'(cpu_reset), 32'd1);
        ticks(5);
        check("rseq_ce_e10", 32'(cpu_ce), 32'd1);
        ticks(5);
        check("rseq_ce_e15", 32'(cpu_ce), 32'd1);
        check("rseq_reset_e15", 32'(cpu_reset), 32'd1);
        tick();
        check("rseq_reset_drop", 32'(cpu_reset), 32'd0);
        check("rseq_state_stop", 32'(state_dbg), 32'(ST_STOP));
        check("rseq_count", 32'(cycle_count), 32'd0);
        check("rseq_pulses", 32'(ce_total), 32'd3);

        // glitchy step press: only the long low stretch registers
        key_step_n = 1'b0;
        ticks(2);
        key_step_n = 1'b1;
        ticks(2);
        key_step_n = 1'b0;
        ce_snap = ce_total;
        ticks(6);
        check("step_ce_early", 32'(cpu_ce), 32'd0);
        tick();
        check("step_ce", 32'(cpu_ce), 32'd1);
        tick();
        check("step_ce_off", 32'(cpu_ce), 32'd0);
        check("step_count", 32'(cycle_count), 32'd1);
        ticks(8);
        key_step_n = 1'b1;
        ticks(10);
        check("step_one_pulse", 32'(ce_total - ce_snap), 32'd1);

        // free run
        key_mode_n = 1'b0;
        ticks(6);
        check("run_not_yet", 32'(running), 32'd0);
        tick();
        check("run_running", 32'(running), 32'd1);
        check("run_state", 32'(state_dbg), 32'(ST_RUN));
        key_mode_n = 1'b1;
        ticks(4);
        check("run_first_early", 32'(cpu_ce), 32'd0);
        tick();
        check("run_first_pulse", 32'(cpu_ce), 32'd1);
        for (int i = 2; i <= 9; i++) wait_ce("run_pulse");
        tick();
        key_mode_n = 1'b0;
        ticks(4);
        check("run_pulse10", 32'(cpu_ce), 32'd1);
        ticks(2);
        check("stop_still_running", 32'(running), 32'd1);
        tick();
        check("stop_running", 32'(running), 32'd0);
        check("stop_state", 32'(state_dbg), 32'(ST_STOP));
        key_mode_n = 1'b1;
        ce_snap = ce_total;
        ticks(30);
        check("stop_no_ce", 32'(ce_total - ce_snap), 32'd0);
        check("stop_count", 32'(cycle_count), 32'd11);

        // breakpoint on the 4th run pulse
        bp_en   = 1'b1;
        bp_addr = 16'h8004;
        key_mode_n = 1'b0;
        ticks(7);
        check("bp_running", 32'(running), 32'd1);
        key_mode_n = 1'b1;
        for (int i = 1; i <= 3; i++) wait_ce("bp_run_pulse");
        tick();
        cpu_addr = 16'h8004;
        wait_ce("bp_pulse4");
        check("bp_not_yet", 32'(bp_hit), 32'd0);
        tick();
        check("bp_hit", 32'(bp_hit), 32'd1);
        check("bp_running_off", 32'(running), 32'd0);
        check("bp_state", 32'(state_dbg), 32'(ST_BP));
        check("bp_count", 32'(cycle_count), 32'd15);
        cpu_addr = 16'h0000;
        ce_snap = ce_total;
        ticks(50);
        check("bp_no_ce", 32'(ce_total - ce_snap), 32'd0);
        check("bp_hold", 32'(bp_hit), 32'd1);
        key_step_n = 1'b0;
        ticks(6);
        check("bp_step_early", 32'(cpu_ce), 32'd0);
        tick();
        check("bp_step_ce", 32'(cpu_ce), 32'd1);
        check("bp_step_clear", 32'(bp_hit), 32'd0);
        check("bp_step_state", 32'(state_dbg), 32'(ST_STOP));
        key_step_n = 1'b1;
        ticks(10);
        check("bp_step_count", 32'(cycle_count), 32'd16);

        // counter wrap
        force dut.r_cycle_cnt = 24'hFF_FFFF;
        #1;
        release dut.r_cycle_cnt;
        check("wrap_preload", 32'(cycle_count), 32'h00FF_FFFF);
        key_step_n = 1'b0;
        ticks(7);
        check("wrap_step_ce", 32'(cpu_ce), 32'd1);
        tick();
        check("wrap_count", 32'(cycle_count), 32'd0);
        key_step_n = 1'b1;
        ticks(10);

        // reset key and mode key in the same clk while running
        key_mode_n = 1'b0;
        ticks(7);
        check("rk_running", 32'(running), 32'd1);
        key_mode_n = 1'b1;
        ticks(20);
        key_mode_n  = 1'b0;
        key_reset_n = 1'b0;
        ticks(6);
        check("rk_before_reset", 32'(cpu_reset), 32'd0);
        check("rk_before_run", 32'(running), 32'd1);
        tick();
        check("rk_reset_wins", 32'(cpu_reset), 32'd1);
        check("rk_state", 32'(state_dbg), 32'(ST_RESET));
        check("rk_running_off", 32'(running), 32'd0);
        check("rk_count", 32'(cycle_count), 32'd5);
        key_mode_n  = 1'b1;
        key_reset_n = 1'b1;
        ticks(4);
        check("rk_ce_early", 32'(cpu_ce), 32'd0);
        tick();
        check("rk_pulse1", 32'(cpu_ce), 32'd1);
        ticks(10);
        check("rk_pulse3", 32'(cpu_ce), 32'd1);
        check("rk_pulse3_reset", 32'(cpu_reset), 32'd1);
        tick();
        check("rk_release", 32'(cpu_reset), 32'd0);
        check("rk_stopped", 32'(state_dbg), 32'(ST_STOP));
        check("rk_count_kept", 32'(cycle_count), 32'd5);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
